mem_access_unit: RTL and testbench

Load/store sequencer sitting directly upstream of the 256×16 data memory. Accepts one load or store request at a time from the execute stage over a valid/ready handshake. Drives the memory's level-sensitive `memread`/`memwrite`/`address`/`data_in` pins with glitch-free, registered timing. Returns load data and destination register to writeback over a second valid/ready handshake.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer in front of the 256x16 data memory:
// widths, FSM state encoding and the latched request record.
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int RD_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_GUARD = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [RD_W-1:0]   rd;
    } mem_req_t;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one request at a time, registered glitch-free memory pins,
// load results returned to writeback over a valid/ready handshake.
module mem_access_unit #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int RD_W   = mem_pkg::RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [RD_W-1:0]   resp_rd,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] mem_dout
);
    import mem_pkg::*;

    state_t            state_r;
    state_t            next_state_s;
    mem_req_t          req_r;
    logic              accept_s;
    logic              req_ready_nxt_s;
    logic              resp_valid_nxt_s;
    logic              memread_nxt_s;
    logic              memwrite_nxt_s;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic              memread_r;
    logic              memwrite_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic [RD_W-1:0]   resp_rd_r;

    assign accept_s = (state_r == ST_IDLE) & req_ready_r & req_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = req_we ? ST_WR : ST_RD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD:    next_state_s = ST_RESP;
            ST_WR:    next_state_s = ST_GUARD;
            ST_GUARD: next_state_s = ST_IDLE;
            ST_RESP: begin
                if (resp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: values the pins take once the next state is entered
    always_comb begin
        req_ready_nxt_s  = 1'b0;
        resp_valid_nxt_s = 1'b0;
        memread_nxt_s    = 1'b0;
        memwrite_nxt_s   = 1'b0;
        case (next_state_s)
            ST_IDLE:  req_ready_nxt_s  = 1'b1;
            ST_RD:    memread_nxt_s    = 1'b1;
            ST_WR:    memwrite_nxt_s   = 1'b1;
            ST_RESP:  resp_valid_nxt_s = 1'b1;
            ST_GUARD: req_ready_nxt_s  = 1'b0;
            default:  req_ready_nxt_s  = 1'b0;
        endcase
    end

    // Control output registers; reset clears memwrite without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            memread_r    <= 1'b0;
            memwrite_r   <= 1'b0;
        end else begin
            req_ready_r  <= req_ready_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            memread_r    <= memread_nxt_s;
            memwrite_r   <= memwrite_nxt_s;
        end
    end

    // Request latch; address/data pins only move on acceptance so GUARD holds them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r <= '{we: 1'b0, addr: {ADDR_W{1'b0}}, wdata: {DATA_W{1'b0}}, rd: {RD_W{1'b0}}};
        end else if (accept_s) begin
            req_r <= '{we: req_we, addr: req_addr, wdata: req_wdata, rd: req_rd};
        end else begin
            req_r <= req_r;
        end
    end

    // Load data capture at the end of the read cycle, held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata_r <= {DATA_W{1'b0}};
            resp_rd_r    <= {RD_W{1'b0}};
        end else if ((state_r == ST_RD) && !req_r.we) begin
            resp_rdata_r <= mem_dout;
            resp_rd_r    <= req_r.rd;
        end else begin
            resp_rdata_r <= resp_rdata_r;
            resp_rd_r    <= resp_rd_r;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_rd    = resp_rd_r;
    assign memread    = memread_r;
    assign memwrite   = memwrite_r;
    assign address    = req_r.addr;
    assign data_in    = req_r.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, multi-cycle corner
// sequences and a random load/store stream against a plain reference memory.
module tb_mem_access_unit;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int RD_W   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = 8'h00;
    logic [DATA_W-1:0] req_wdata = 16'h0000;
    logic [RD_W-1:0]   req_rd = 3'd0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_rdata;
    logic [RD_W-1:0]   resp_rd;
    logic              memread;
    logic              memwrite;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] mem_dout;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .memread(memread), .memwrite(memwrite), .address(address),
        .data_in(data_in), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Level-sensitive data memory seen by the DUT, plus an independent reference image
    logic [DATA_W-1:0] mem [256] = '{default: 16'h0000};
    logic [DATA_W-1:0] ref_mem [256] = '{default: 16'h0000};
    assign mem_dout = mem[address];
    always @(posedge clk) if (memwrite) mem[address] <= data_in;

    int cyc = 0;
    int acc_q[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && req_valid && req_ready) acc_q.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pin-level invariants sampled mid-cycle
    logic              prev_mw = 1'b0;
    logic [ADDR_W-1:0] prev_addr = 8'h00;
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            chk("rd_wr_exclusive", {31'd0, memread & memwrite}, 32'd0);
            if (prev_mw) chk("addr_stable_after_write", {24'd0, address}, {24'd0, prev_addr});
            prev_mw   = memwrite;
            prev_addr = address;
        end else begin
            prev_mw = 1'b0;
        end
    end

    task automatic wait_ready(output logic ok);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok) chk("req_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [7:0] a, input logic [15:0] wd,
                          input logic [2:0] rd, input int hold, input logic [15:0] exp);
        logic ok;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_rd = rd;
        wait_ready(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (we) begin
            chk("st_memwrite", {31'd0, memwrite}, 32'd1);
            chk("st_memread", {31'd0, memread}, 32'd0);
            chk("st_address", {24'd0, address}, {24'd0, a});
            chk("st_data_in", {16'd0, data_in}, {16'd0, wd});
            @(negedge clk);
            chk("guard_memwrite", {31'd0, memwrite}, 32'd0);
            chk("guard_address", {24'd0, address}, {24'd0, a});
            chk("guard_data_in", {16'd0, data_in}, {16'd0, wd});
            chk("guard_ready", {31'd0, req_ready}, 32'd0);
            chk("st_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
            chk("st_ready_again", {31'd0, req_ready}, 32'd1);
            ref_mem[a] = wd;
        end else begin
            chk("ld_memread", {31'd0, memread}, 32'd1);
            chk("ld_memwrite", {31'd0, memwrite}, 32'd0);
            chk("ld_address", {24'd0, address}, {24'd0, a});
            chk("ld_early_valid", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
            chk("ld_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("ld_rdata", {16'd0, resp_rdata}, {16'd0, exp});
            chk("ld_rd", {29'd0, resp_rd}, {29'd0, rd});
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("stall_valid", {31'd0, resp_valid}, 32'd1);
                chk("stall_rdata", {16'd0, resp_rdata}, {16'd0, exp});
                chk("stall_rd", {29'd0, resp_rd}, {29'd0, rd});
                chk("stall_memread", {31'd0, memread}, 32'd0);
                chk("stall_ready", {31'd0, req_ready}, 32'd0);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            chk("ld_resp_done", {31'd0, resp_valid}, 32'd0);
            chk("ld_ready_again", {31'd0, req_ready}, 32'd1);
        end
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [2:0]  rd;
        int          hold;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic        ok;
        logic        r_we;
        logic [7:0]  r_a;
        logic [15:0] r_wd;
        logic [2:0]  r_rd;

        vecs[0] = '{1'b1, 8'h10, 16'hBEEF, 3'd0, 0, 16'h0000};
        vecs[1] = '{1'b0, 8'h10, 16'h0000, 3'd5, 0, 16'hBEEF};
        vecs[2] = '{1'b0, 8'h10, 16'h0000, 3'd3, 5, 16'hBEEF};
        vecs[3] = '{1'b1, 8'h40, 16'hA5A5, 3'd0, 0, 16'h0000};
        vecs[4] = '{1'b0, 8'h40, 16'h0000, 3'd7, 1, 16'hA5A5};
        vecs[5] = '{1'b0, 8'h41, 16'h0000, 3'd2, 0, 16'h0000};

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_memread", {31'd0, memread}, 32'd0);
        chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
        chk("rst_address", {24'd0, address}, 32'd0);
        chk("rst_data_in", {16'd0, data_in}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("release_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 6; i++)
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].hold, vecs[i].exp_rdata);

        // Back-to-back stores with req_valid held high
        acc_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFF; req_wdata = 16'h1234;
        wait_ready(ok);
        @(negedge clk);
        req_addr = 8'h00; req_wdata = 16'h5678;
        for (int n = 0; n < 20 && acc_q.size() < 2; n++) @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_accepts", acc_q.size(), 32'd2);
        if (acc_q.size() >= 2) chk("b2b_interval", acc_q[1] - acc_q[0], 32'd3);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_mem_ff", {16'd0, mem[8'hFF]}, 32'h1234);
        chk("b2b_mem_00", {16'd0, mem[8'h00]}, 32'h5678);
        ref_mem[8'hFF] = 16'h1234;
        ref_mem[8'h00] = 16'h5678;

        // Reset during the write cycle of a store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 16'hDEAD;
        wait_ready(ok);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_pre_memwrite", {31'd0, memwrite}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_memwrite", {31'd0, memwrite}, 32'd0);
        chk("abort_memread", {31'd0, memread}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_rdata", {16'd0, resp_rdata}, 32'd0);
        chk("abort_rd", {29'd0, resp_rd}, 32'd0);
        chk("abort_address", {24'd0, address}, 32'd0);
        chk("abort_data_in", {16'd0, data_in}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_release_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("abort_mem_untouched", {16'd0, mem[8'h20]}, 32'h0000);
        do_req(1'b0, 8'h20, 16'h0000, 3'd6, 0, ref_mem[8'h20]);
        do_req(1'b0, 8'h10, 16'h0000, 3'd1, 0, ref_mem[8'h10]);

        // Random stream against the reference image
        for (int k = 0; k < 60; k++) begin
            r_we = 1'($urandom_range(0, 1));
            r_a  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            r_wd = 16'($urandom);
            r_rd = 3'($urandom_range(0, 7));
            do_req(r_we, r_a, r_wd, r_rd, $urandom_range(0, 2), ref_mem[r_a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
